// File: rtl/bp_update_ctrl_pkg.sv
// Shared constants for the branch-predictor update controller:
// counter encodings, table geometry and controller states.
package bp_update_ctrl_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int BP_TAG_WIDTH  = 8;
    localparam int BP_TABLE_SIZE = 256;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam logic [1:0] BP_INIT_VALUE = CNT_WNT;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bp_state_e;
endpackage

// File: rtl/bp_fb_fifo.sv
// Commit-feedback FIFO holding {tag, jump}; push/pop arrive pre-qualified
// by the controller, so an idle cycle simply holds state.
module bp_fb_fifo
    import bp_update_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH = BP_TAG_WIDTH,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [TAG_WIDTH-1:0]   push_tag_i,
    input  logic                   push_jump_i,
    input  logic                   pop_i,
    output logic [TAG_WIDTH-1:0]   head_tag_o,
    output logic                   head_jump_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [TAG_WIDTH:0] mem_q [DEPTH];
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PW:0]        count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= {push_tag_i, push_jump_i};
    end

    assign head_tag_o  = mem_q[head_q][TAG_WIDTH:1];
    assign head_jump_o = mem_q[head_q][0];
    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
endmodule

// File: rtl/bp_update_ctrl.sv
// Sequencer for the 2-bit predictor table: walks the table once after reset,
// then drains ROB feedback with one read-modify-write per cycle.
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int         TAG_WIDTH  = BP_TAG_WIDTH,
    parameter int         TABLE_SIZE = BP_TABLE_SIZE,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_VALUE = BP_INIT_VALUE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_rob_bp_ce,
    input  logic [TAG_WIDTH-1:0] in_rob_tag,
    input  logic                 in_rob_jump_ce,
    output logic                 out_rob_full,
    input  logic [TAG_WIDTH-1:0] in_fetcher_tag,
    output logic                 out_fetcher_jump_ce,
    output logic [TAG_WIDTH-1:0] out_tbl_fetch_raddr,
    input  logic [1:0]           in_tbl_fetch_rdata,
    output logic [TAG_WIDTH-1:0] out_tbl_upd_raddr,
    input  logic [1:0]           in_tbl_upd_rdata,
    output logic                 out_tbl_we,
    output logic [TAG_WIDTH-1:0] out_tbl_waddr,
    output logic [1:0]           out_tbl_wdata,
    output logic                 out_init_done,
    output logic [15:0]          out_drop_cnt
);
    bp_state_e            state_q, state_d;
    logic [TAG_WIDTH-1:0] init_idx_q, init_idx_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic                 push, pop;
    logic [TAG_WIDTH-1:0] head_tag;
    logic                 head_jump, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    bp_fb_fifo #(
        .TAG_WIDTH (TAG_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_tag_i  (in_rob_tag),
        .push_jump_i (in_rob_jump_ce),
        .pop_i       (pop),
        .head_tag_o  (head_tag),
        .head_jump_o (head_jump),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        drop_cnt_d    = drop_cnt_q;
        out_tbl_we    = FALSE;
        out_tbl_waddr = init_idx_q;
        out_tbl_wdata = INIT_VALUE;
        push          = FALSE;
        pop           = FALSE;
        if (!rst && rdy) begin
            case (state_q)
                S_INIT: begin
                    out_tbl_we = TRUE;
                    init_idx_d = init_idx_q + 1'b1;
                    if (init_idx_q == TAG_WIDTH'(TABLE_SIZE-1)) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!fifo_empty) begin
                        pop           = TRUE;
                        out_tbl_we    = TRUE;
                        out_tbl_waddr = head_tag;
                        if (head_jump)
                            out_tbl_wdata = (in_tbl_upd_rdata == CNT_ST) ? CNT_ST
                                          : in_tbl_upd_rdata + 2'd1;
                        else
                            out_tbl_wdata = (in_tbl_upd_rdata == CNT_SNT) ? CNT_SNT
                                          : in_tbl_upd_rdata - 2'd1;
                    end
                end
                default: state_d = S_INIT;
            endcase
            // A pop in the same cycle frees the slot a full FIFO needs.
            if (in_rob_bp_ce) begin
                if (!fifo_full || pop)
                    push = TRUE;
                else if (drop_cnt_q != 16'hFFFF)
                    drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{in_tbl_fetch_rdata[0], fifo_count};

    assign out_init_done       = (state_q == S_RUN) && !rst;
    assign out_fetcher_jump_ce = out_init_done && in_tbl_fetch_rdata[1];
    assign out_rob_full        = fifo_full && !rst;
    assign out_tbl_fetch_raddr = in_fetcher_tag;
    assign out_tbl_upd_raddr   = head_tag;
    assign out_drop_cnt        = drop_cnt_q;
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: a queue/array model of the controller checked on
// every falling edge, directed scenarios with literal pins, then random traffic.
module tb_bp_update_ctrl;
    localparam int TS = 256;
    localparam int FD = 4;

    logic       clk = 1'b0, rst = 1'b1, rdy = 1'b0;
    logic       bp_ce = 1'b0, jump = 1'b0;
    logic [7:0] rob_tag = '0, f_tag = '0;
    logic       full, jce, we, done;
    logic [7:0] fetch_raddr, upd_raddr, waddr;
    logic [1:0] fetch_rdata, upd_rdata, wdata;
    logic [15:0] drop;

    bp_update_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_rob_bp_ce(bp_ce), .in_rob_tag(rob_tag), .in_rob_jump_ce(jump),
        .out_rob_full(full), .in_fetcher_tag(f_tag), .out_fetcher_jump_ce(jce),
        .out_tbl_fetch_raddr(fetch_raddr), .in_tbl_fetch_rdata(fetch_rdata),
        .out_tbl_upd_raddr(upd_raddr), .in_tbl_upd_rdata(upd_rdata),
        .out_tbl_we(we), .out_tbl_waddr(waddr), .out_tbl_wdata(wdata),
        .out_init_done(done), .out_drop_cnt(drop)
    );

    always #5 clk = ~clk;

    // Environment table, written only by the DUT.
    logic [1:0] tbl [TS];
    initial for (int i = 0; i < TS; i++) tbl[i] = 2'b11;
    always @(posedge clk) if (we) tbl[waddr] <= wdata;
    assign fetch_rdata = tbl[fetch_raddr];
    assign upd_rdata   = tbl[upd_raddr];

    int total = 0, bad = 0;
    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    bit  m_done = 0;
    int  m_idx = 0, m_drop = 0;
    int  mtbl [TS];
    int  mq_tag [$];
    bit  mq_jmp [$];
    bit  chk_en = 0;
    int  ewe, ea, ed, v;
    int  log_a [$], log_d [$];
    initial for (int i = 0; i < TS; i++) mtbl[i] = 3;

    always @(negedge clk) begin
        if (we === 1'b1) begin log_a.push_back(waddr); log_d.push_back(wdata); end
        ewe = 0; ea = 0; ed = 0;
        if (!rst && rdy) begin
            if (!m_done) begin ewe = 1; ea = m_idx; ed = 1; end
            else if (mq_tag.size() > 0) begin
                ewe = 1; ea = mq_tag[0]; v = mtbl[ea];
                ed = mq_jmp[0] ? ((v == 3) ? 3 : v + 1) : ((v == 0) ? 0 : v - 1);
            end
        end
        if (chk_en) begin
            chk("we", we, ewe);
            chk("fetch_raddr", fetch_raddr, f_tag);
            if (rst) begin
                chk("done_rst", done, 0);
                chk("jce_rst", jce, 0);
                chk("full_rst", full, 0);
            end else begin
                chk("done", done, m_done);
                chk("jce", jce, m_done ? (mtbl[f_tag] >> 1) : 0);
                chk("full", full, mq_tag.size() == FD);
                chk("drop", drop, m_drop);
                if (ewe != 0) begin
                    chk("waddr", waddr, ea);
                    chk("wdata", wdata, ed);
                    if (m_done) chk("upd_raddr", upd_raddr, ea);
                end
            end
        end
        if (rst) begin
            m_done = 0; m_idx = 0; m_drop = 0;
            mq_tag.delete(); mq_jmp.delete();
        end else if (rdy) begin
            if (ewe != 0) mtbl[ea] = ed;
            if (!m_done) begin
                m_idx++;
                if (m_idx == TS) begin m_done = 1; m_idx = 0; end
            end else if (mq_tag.size() > 0) begin
                void'(mq_tag.pop_front()); void'(mq_jmp.pop_front());
            end
            if (bp_ce) begin
                if (mq_tag.size() < FD) begin mq_tag.push_back(rob_tag); mq_jmp.push_back(jump); end
                else if (m_drop < 65535) m_drop++;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(string name, output int n);
        n = 0;
        while (done !== 1'b1 && n < 400) begin cyc(1); n++; end
        if (n >= 400) chk({name, "_timeout"}, 0, 1);
    endtask

    int n, okc;
    int exp_t [5] = '{20, 21, 22, 23, 30};
    int exp_d [5] = '{0, 2, 0, 2, 2};

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1; cyc(1); chk_en = 1; cyc(1);
        // Init with 5 pushes: 4 fit, 1 dropped
        rst = 0; rdy = 1; f_tag = 0; log_a.delete(); log_d.delete();
        for (int i = 0; i < 5; i++) begin
            bp_ce = 1; rob_tag = 8'(20 + i); jump = i[0]; cyc(1);
        end
        bp_ce = 0;
        chk("full_after_4", full, 1);
        chk("drop_after_5", drop, 1);
        wait_done("init1", n);
        chk("init_cycles", n + 5, 256);
        okc = 0;
        for (int i = 0; i < 256 && i < log_a.size(); i++)
            if (log_a[i] == i && log_d[i] == 1) okc++;
        chk("init_writes", okc, 256);
        chk("init_log_len", log_a.size(), 256);
        // Full FIFO, simultaneous push and pop
        log_a.delete(); log_d.delete();
        bp_ce = 1; rob_tag = 30; jump = 1; cyc(1); bp_ce = 0;
        chk("full_pushpop", full, 1);
        chk("drop_pushpop", drop, 1);
        cyc(4);
        chk("drain_len", log_a.size(), 5);
        for (int i = 0; i < 5 && i < log_a.size(); i++) begin
            chk("drain_tag", log_a[i], exp_t[i]);
            chk("drain_data", log_d[i], exp_d[i]);
        end
        // Tag 5 taken three times back-to-back
        log_a.delete(); log_d.delete();
        for (int i = 0; i < 3; i++) begin bp_ce = 1; rob_tag = 5; jump = 1; cyc(1); end
        bp_ce = 0; cyc(3);
        chk("t5_len", log_a.size(), 3);
        if (log_a.size() == 3) begin
            chk("t5_w0", log_d[0], 2); chk("t5_w1", log_d[1], 3); chk("t5_w2", log_d[2], 3);
        end
        f_tag = 5; #1;
        chk("t5_pred", jce, 1);
        // Tag 9: 01 -> 00, saturate at 00, then taken -> 01
        log_a.delete(); log_d.delete();
        for (int i = 0; i < 3; i++) begin bp_ce = 1; rob_tag = 9; jump = (i == 2); cyc(1); end
        bp_ce = 0; cyc(3);
        chk("t9_len", log_a.size(), 3);
        if (log_a.size() == 3) begin
            chk("t9_w0", log_d[0], 0); chk("t9_w1", log_d[1], 0); chk("t9_w2", log_d[2], 1);
        end
        // Reset mid-init with an rdy pause
        rst = 1; cyc(1); rst = 0; log_a.delete(); log_d.delete();
        cyc(100);
        chk("pre_pause_last", log_a.size() > 0 ? log_a[log_a.size()-1] : -1, 99);
        log_a.delete(); log_d.delete();
        rdy = 0; bp_ce = 1; cyc(10); bp_ce = 0;
        chk("pause_writes", log_a.size(), 0);
        chk("pause_drop", drop, 0);
        rdy = 1; cyc(1);
        chk("resume_addr", log_a.size() > 0 ? log_a[0] : -1, 100);
        rst = 1; cyc(1); rst = 0; log_a.delete(); log_d.delete(); cyc(1);
        chk("rst_init_addr", log_a.size() > 0 ? log_a[0] : -1, 0);
        chk("rst_init_data", log_d.size() > 0 ? log_d[0] : -1, 1);
        // Reset mid-run with 3 entries queued
        for (int i = 0; i < 4; i++) begin bp_ce = 1; rob_tag = 8'(40 + i); jump = 1; cyc(1); end
        bp_ce = 0;
        wait_done("init2", n);
        cyc(1);
        rst = 1; cyc(1); rst = 0;
        chk("rst_run_full", full, 0);
        log_a.delete(); log_d.delete(); cyc(1);
        chk("rst_run_addr", log_a.size() > 0 ? log_a[0] : -1, 0);
        wait_done("init3", n);
        log_a.delete(); log_d.delete(); cyc(3);
        chk("rst_run_empty", log_a.size(), 0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rdy     = ($urandom_range(7) != 0);
            bp_ce   = $urandom_range(1);
            jump    = $urandom_range(1);
            rob_tag = 8'($urandom_range(7));
            f_tag   = 8'($urandom_range(7));
            rst     = ($urandom_range(699) == 0);
            cyc(1);
        end
        rst = 0; bp_ce = 0; cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Controller and sequencer for the 2-bit saturating branch-predictor table.
- Initialises the table one entry per cycle after reset, replacing a one-shot reset loop.
- Buffers ROB commit feedback in a small FIFO and applies one read-modify-write update per cycle through the table's single write port.
- Gates fetcher predictions until initialisation completes; sits between the ROB commit path, the fetcher and a plain dual-read/single-write predictor table.

Parameters:
- TAG_WIDTH, 8: predictor index width; equals the shared BP tag width.
- TABLE_SIZE, 256: number of table entries; must equal 2**TAG_WIDTH.
- FIFO_DEPTH, 4: commit-feedback FIFO entries; power of two, at least 2.
- INIT_VALUE, 2'b01: counter value written during initialisation (weakly not-taken).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds and no table write occurs
- in_rob_bp_ce  in  1  ROB commit of a branch; push request
- in_rob_tag  in  TAG_WIDTH  table index of the committed branch
- in_rob_jump_ce  in  1  branch was taken
- out_rob_full  out  1  FIFO full (registered count == FIFO_DEPTH)
- in_fetcher_tag  in  TAG_WIDTH  fetcher lookup index
- out_fetcher_jump_ce  out  1  prediction: taken
- out_tbl_fetch_raddr  out  TAG_WIDTH  table read port A address; equals in_fetcher_tag
- in_tbl_fetch_rdata  in  2  table read port A data (asynchronous read)
- out_tbl_upd_raddr  out  TAG_WIDTH  table read port B address; equals FIFO head tag
- in_tbl_upd_rdata  in  2  table read port B data (asynchronous read)
- out_tbl_we  out  1  table write enable
- out_tbl_waddr  out  TAG_WIDTH  table write address
- out_tbl_wdata  out  2  table write data
- out_init_done  out  1  initialisation complete
- out_drop_cnt  out  16  saturating count of dropped commit feedbacks

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- State machine: S_INIT and S_RUN.
- Reset (rst high at a posedge): state=S_INIT, init_idx=0, FIFO emptied (head=tail=count=0), out_drop_cnt=0. A reset asserted mid-init or mid-run restarts initialisation at index 0 and discards buffered feedback.
- Outputs while rst is high: out_tbl_we=0, out_init_done=0, out_fetcher_jump_ce=0, out_rob_full=0.
- S_INIT, per cycle with rdy=1:
  - out_tbl_we=1, out_tbl_waddr=init_idx, out_tbl_wdata=INIT_VALUE; init_idx increments.
  - After writing index TABLE_SIZE-1, move to S_RUN. Initialisation takes exactly TABLE_SIZE enabled cycles.
  - The FIFO accepts pushes but does not pop.
- S_RUN, per cycle with rdy=1 and FIFO non-empty:
  - Pop the head; out_tbl_we=1, out_tbl_waddr=head tag.
  - wdata = sat_inc(in_tbl_upd_rdata) if head taken, else sat_dec. 11 stays 11 on taken; 00 stays 00 on not-taken.
  - Exactly one update per cycle.
- S_RUN with FIFO empty: out_tbl_we=0.
- Back-to-back updates to the same tag are correct because the table read reflects writes from the previous edge. No bypass is required.
- Push rule: accepted when rdy=1, in_rob_bp_ce=1, and either count<FIFO_DEPTH or a pop occurs in the same cycle.
  - Full with a simultaneous pop: push accepted, count unchanged.
  - Full without a pop: feedback dropped, out_drop_cnt increments, saturating at 16'hFFFF.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop on an empty FIFO is impossible, since a pop needs a valid head; the pushed entry pops next cycle at the earliest.
- out_fetcher_jump_ce = out_init_done & in_tbl_fetch_rdata[1]. Combinational, zero latency.
- out_init_done = (state==S_RUN), registered.
- rdy=0: all registers hold, out_tbl_we=0, pushes ignored and not counted as dropped.

Decomposition:
- Shared constants package: TRUE/FALSE, BP tag width, BP table size, INIT_VALUE, 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11), state encodings.
- Sub-module bp_fb_fifo: parameterised FIFO holding {tag, jump}, with push/pop/full/empty/count.
- Saturating counter arithmetic stays inline in bp_update_ctrl.

Test Plan:
- Reset, then rdy=1 for 256 cycles: out_tbl_we=1 each cycle, waddr 0..255, wdata=01. out_init_done rises at cycle 257; out_fetcher_jump_ce=0 throughout init even with in_tbl_fetch_rdata=11.
- After init, push tag=5 taken three times back-to-back with table model starting at 01: writes to 5 are 10, 11, 11; prediction for tag 5 becomes 1.
- Push tag=9 not-taken with entry 00: write 00 (saturate). Push taken: write 01.
- During init, push 5 feedbacks with FIFO_DEPTH=4: out_rob_full=1 after 4 pushes, out_drop_cnt=1. After init, 4 writes occur in consecutive cycles in FIFO order.
- Full FIFO in S_RUN with simultaneous push and pop: push accepted, count stays 4, out_drop_cnt unchanged.
- Assert rst at init_idx=100, and separately mid-run with 3 entries queued: next enabled write is waddr=0 with INIT_VALUE, FIFO empty. Hold rdy=0 for 10 cycles mid-init: no writes, init_idx frozen.
